audio_sample_sequencer: RTL

Sequences one stereo audio sample at a time between the audio codec's read/write FIFO handshake and a pair of per-channel FIR filters (left and right). It reads one sample pair, issues exactly one filter-advance strobe per sample, waits a fixed filter latency, and writes the filtered (or bypassed) pair back to the codec. Advancing the filters only once per codec sample keeps their delay lines sample-synchronous instead of clock-synchronous. It also counts completed samples and samples dropped on write stall.

---
 rtl/audio_seq_pkg.sv | 25 ++
 rtl/seq_timer.sv | 41 ++++
 rtl/audio_sample_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/audio_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_seq_pkg
// Description : Shared types and widths for the audio sample sequencer.
//               Provides the sequencer state enum plus the sample width and
//               counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_seq_pkg;

  localparam int SAMPLE_W = 24;
  localparam int CNT_W    = 16;
  localparam int DROP_W   = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    ADV     = 3'd2,
    SETTLE  = 3'd3,
    WAIT_WR = 3'd4,
    WRITE   = 3'd5
  } seq_state_t;

endpackage : audio_seq_pkg
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_timer
// Description : 16-bit loadable down-counter with an at-one flag. One timer
//               is shared by the filter-settle and write-wait phases of the
//               sequencer; only one phase uses it at a time.
// Ports       : clk_i     - clock
//               rst_i     - synchronous active-high reset (count -> 0)
//               load_i    - load value_i (has priority over dec_i)
//               value_i   - load value
//               dec_i     - decrement by one
//               at_one_o  - count equals 1
// Revision    : 1.0 - initial release
// ============================================================================
module seq_timer
  import audio_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             at_one_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (dec_i) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign at_one_o = (count_q == CNT_W'(1));

endmodule : seq_timer
`default_nettype wire

// File: rtl/audio_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : audio_sample_sequencer
// Description : Moves one stereo sample at a time from the codec read FIFO
//               through the external left/right FIR filters (or around them
//               in bypass) and back to the codec write FIFO. The filters are
//               advanced once per codec sample. Counts completed writes and
//               samples dropped when the write side stalls too long.
// Ports       : clock_i / reset_i             - clock, sync active-high reset
//               read_ready_i, readdata_*_i    - codec input pair available
//               read_o                        - pop codec input FIFO
//               write_ready_i, writedata_*_o  - codec output side
//               write_o                       - push codec output FIFO
//               filter_on_i                   - 1 filter, 0 bypass
//               filt_in_*_o, filt_advance_o   - filter inputs / shift strobe
//               filt_out_*_i                  - filter results
//               sample_count_o, drop_count_o  - statistics
//               busy_o                        - not idle
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int W        = SAMPLE_W,
  parameter int FILT_LAT = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              read_ready_i,
  input  logic [W-1:0]      readdata_left_i,
  input  logic [W-1:0]      readdata_right_i,
  output logic              read_o,
  input  logic              write_ready_i,
  output logic [W-1:0]      writedata_left_o,
  output logic [W-1:0]      writedata_right_o,
  output logic              write_o,
  input  logic              filter_on_i,
  output logic [W-1:0]      filt_in_left_o,
  output logic [W-1:0]      filt_in_right_o,
  output logic              filt_advance_o,
  input  logic [W-1:0]      filt_out_left_i,
  input  logic [W-1:0]      filt_out_right_i,
  output logic [CNT_W-1:0]  sample_count_o,
  output logic [DROP_W-1:0] drop_count_o,
  output logic              busy_o
);

  seq_state_t        state_q, state_d;
  logic              mode_q;
  logic              read_q, write_q, filt_advance_q, busy_q;
  logic [W-1:0]      filt_in_left_q, filt_in_right_q;
  logic [W-1:0]      writedata_left_q, writedata_right_q;
  logic [CNT_W-1:0]  sample_count_q;
  logic [DROP_W-1:0] drop_count_q;

  logic              w_tmr_load, w_tmr_dec, w_tmr_at_one;
  logic [CNT_W-1:0]  w_tmr_value;

  // Timer: loaded with the filter latency in ADV, reloaded with the write
  // timeout on the last SETTLE cycle. In WAIT_WR it only counts while the
  // codec is not ready, so a late write_ready on the final cycle still wins.
  assign w_tmr_load  = (state_q == ADV) || ((state_q == SETTLE) && w_tmr_at_one);
  assign w_tmr_value = (state_q == ADV) ? CNT_W'(FILT_LAT) : CNT_W'(TIMEOUT);
  assign w_tmr_dec   = ((state_q == SETTLE) && !w_tmr_at_one) ||
                       ((state_q == WAIT_WR) && !write_ready_i && !w_tmr_at_one);

  seq_timer u_timer (
    .clk_i    (clock_i),
    .rst_i    (reset_i),
    .load_i   (w_tmr_load),
    .value_i  (w_tmr_value),
    .dec_i    (w_tmr_dec),
    .at_one_o (w_tmr_at_one)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (read_ready_i) state_d = READ;
      READ:    state_d = ADV;
      ADV:     state_d = SETTLE;
      SETTLE:  if (w_tmr_at_one) state_d = WAIT_WR;
      WAIT_WR: begin
        if (write_ready_i)     state_d = WRITE;
        else if (w_tmr_at_one) state_d = IDLE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with
  // the state they belong to and are glitch-free at the ports.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q           <= IDLE;
      mode_q            <= 1'b0;
      read_q            <= 1'b0;
      write_q           <= 1'b0;
      filt_advance_q    <= 1'b0;
      busy_q            <= 1'b0;
      filt_in_left_q    <= '0;
      filt_in_right_q   <= '0;
      writedata_left_q  <= '0;
      writedata_right_q <= '0;
      sample_count_q    <= '0;
      drop_count_q      <= '0;
    end else begin
      state_q        <= state_d;
      read_q         <= (state_d == READ);
      write_q        <= (state_d == WRITE);
      busy_q         <= (state_d != IDLE);
      // ADV is only entered from READ, where filter_on_i is latched as mode.
      filt_advance_q <= (state_d == ADV) && filter_on_i;

      if (state_q == READ) begin
        filt_in_left_q  <= readdata_left_i;
        filt_in_right_q <= readdata_right_i;
        mode_q          <= filter_on_i;
      end

      if ((state_q == SETTLE) && w_tmr_at_one) begin
        writedata_left_q  <= mode_q ? filt_out_left_i  : filt_in_left_q;
        writedata_right_q <= mode_q ? filt_out_right_i : filt_in_right_q;
      end

      if (state_d == WRITE) begin
        sample_count_q <= sample_count_q + 1'b1;
      end

      if ((state_q == WAIT_WR) && (state_d == IDLE) && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
    end
  end

  assign read_o            = read_q;
  assign write_o           = write_q;
  assign filt_advance_o    = filt_advance_q;
  assign busy_o            = busy_q;
  assign filt_in_left_o    = filt_in_left_q;
  assign filt_in_right_o   = filt_in_right_q;
  assign writedata_left_o  = writedata_left_q;
  assign writedata_right_o = writedata_right_q;
  assign sample_count_o    = sample_count_q;
  assign drop_count_o      = drop_count_q;

endmodule : audio_sample_sequencer
`default_nettype wire
